// File: rtl/ac_unit_pkg.sv
// Shared definitions for the AC/E register unit: command codes, FSM state
// encoding, default width and the skip-test evaluator.
package ac_unit_pkg;

  localparam int AC_WIDTH = 16;

  localparam logic [3:0] AC_CMD_NOP      = 4'd0;
  localparam logic [3:0] AC_CMD_LOAD_ALU = 4'd1;
  localparam logic [3:0] AC_CMD_LOAD_DR  = 4'd2;
  localparam logic [3:0] AC_CMD_CLA      = 4'd3;
  localparam logic [3:0] AC_CMD_CLE      = 4'd4;
  localparam logic [3:0] AC_CMD_CMA      = 4'd5;
  localparam logic [3:0] AC_CMD_CME      = 4'd6;
  localparam logic [3:0] AC_CMD_INC      = 4'd7;
  localparam logic [3:0] AC_CMD_SPA      = 4'd8;
  localparam logic [3:0] AC_CMD_SNA      = 4'd9;
  localparam logic [3:0] AC_CMD_SZA      = 4'd10;
  localparam logic [3:0] AC_CMD_SZE      = 4'd11;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } ac_state_t;

  // Width-independent: caller supplies the sign bit and zero flag of ac.
  function automatic logic ac_skip_eval(input logic [3:0] op,
                                        input logic       ac_sign_bit,
                                        input logic       ac_is_zero,
                                        input logic       e_flag);
    case (op)
      AC_CMD_SPA: return !ac_sign_bit && !ac_is_zero;
      AC_CMD_SNA: return ac_sign_bit;
      AC_CMD_SZA: return ac_is_zero;
      AC_CMD_SZE: return !e_flag;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ac_e_register_unit.sv
// Accumulator and E (carry/link) register stage behind the ALU; one command per
// two cycles. Optional macro AC_STATUS_REG_EN registers ac_zero/ac_sign.
module ac_e_register_unit
  import ac_unit_pkg::*;
#(
  parameter int WIDTH = AC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_e_out,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] ac,
  output logic             e,
  output logic             done,
  output logic             skip,
  output logic             ac_zero,
  output logic             ac_sign
);

  ac_state_t        state;
  ac_state_t        state_nxt;
  logic             accept;

  logic [3:0]       op_p0;
  logic [WIDTH-1:0] opnd_p0;
  logic             opnd_e_p0;
  logic             skip_p0;

  logic [WIDTH-1:0] ac_nxt;
  logic             e_nxt;
  logic             vld_p1;
  logic             skip_p1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: capture command, operand and skip decision at accept time.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0     <= cmd_op;
      opnd_p0   <= (cmd_op == AC_CMD_LOAD_DR) ? data_in : alu_result;
      opnd_e_p0 <= alu_e_out;
      skip_p0   <= ac_skip_eval(cmd_op, ac[WIDTH-1], (ac == '0), e);
    end
  end

  // ac/e are stable between accept and EXEC, so CMA/CME/INC see accept-time values.
  always_comb begin
    ac_nxt = ac;
    e_nxt  = e;
    case (op_p0)
      AC_CMD_LOAD_ALU: begin
        ac_nxt = opnd_p0;
        e_nxt  = opnd_e_p0;
      end
      AC_CMD_LOAD_DR: ac_nxt = opnd_p0;
      AC_CMD_CLA:     ac_nxt = '0;
      AC_CMD_CLE:     e_nxt  = 1'b0;
      AC_CMD_CMA:     ac_nxt = ~ac;
      AC_CMD_CME:     e_nxt  = ~e;
      AC_CMD_INC:     ac_nxt = ac + WIDTH'(1);
      default: ;
    endcase
  end

  // Stage p1: commit in EXEC and emit the done/skip pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      ac      <= '0;
      e       <= 1'b0;
      vld_p1  <= 1'b0;
      skip_p1 <= 1'b0;
    end else begin
      vld_p1  <= (state == EXEC);
      skip_p1 <= (state == EXEC) && skip_p0;
      if (state == EXEC) begin
        ac <= ac_nxt;
        e  <= e_nxt;
      end
    end
  end

  assign done = vld_p1;
  assign skip = skip_p1;

`ifdef AC_STATUS_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ac_zero <= 1'b1;
      ac_sign <= 1'b0;
    end else if (state == EXEC) begin
      ac_zero <= (ac_nxt == '0);
      ac_sign <= ac_nxt[WIDTH-1];
    end
  end
`else
  assign ac_zero = (ac == '0);
  assign ac_sign = ac[WIDTH-1];
`endif

endmodule

// File: tb/tb_ac_e_register_unit.sv
// Directed bench for ac_e_register_unit with hand-computed expectations.
module tb_ac_e_register_unit;
  import ac_unit_pkg::*;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_e_out;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] ac;
  logic             e;
  logic             done;
  logic             skip;
  logic             ac_zero;
  logic             ac_sign;

  int n_checks;
  int n_fail;

  ac_e_register_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .alu_result (alu_result),
    .alu_e_out  (alu_e_out),
    .data_in    (data_in),
    .ac         (ac),
    .e          (e),
    .done       (done),
    .skip       (skip),
    .ac_zero    (ac_zero),
    .ac_sign    (ac_sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and check the result cycle after edge N+1.
  task automatic run_cmd(input string tag, input logic [3:0] op,
                         input logic [15:0] alu_v, input logic alu_e,
                         input logic [15:0] din,
                         input logic [15:0] exp_ac, input logic exp_e,
                         input logic exp_skip);
    int budget;
    budget = 0;
    while (!cmd_ready && budget < 10) begin
      tick();
      budget++;
    end
    if (budget >= 10) check_val({tag, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
    cmd_op     = op;
    alu_result = alu_v;
    alu_e_out  = alu_e;
    data_in    = din;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
    alu_result = 16'hDEAD;
    alu_e_out  = ~alu_e;
    data_in    = 16'hBEEF;
    check_val({tag, "_busy"}, 32'(cmd_ready), 32'd0);
    check_val({tag, "_nodone_exec"}, 32'(done), 32'd0);
    tick();
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_skip"}, 32'(skip), 32'(exp_skip));
    check_val({tag, "_ac"}, 32'(ac), 32'(exp_ac));
    check_val({tag, "_e"}, 32'(e), 32'(exp_e));
    check_val({tag, "_zero"}, 32'(ac_zero), 32'(exp_ac == 16'h0000));
    check_val({tag, "_sign"}, 32'(ac_sign), 32'(exp_ac[15]));
  endtask

  logic [3:0] burst_ops [3];

  initial begin
    int n_done;
    int idx;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = AC_CMD_NOP;
    alu_result = '0;
    alu_e_out  = 1'b0;
    data_in    = '0;
    tick();
    tick();
    check_val("rst_ac", 32'(ac), 32'h0);
    check_val("rst_e", 32'(e), 32'd0);
    check_val("rst_ready", 32'(cmd_ready), 32'd1);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_skip", 32'(skip), 32'd0);
    check_val("rst_zero", 32'(ac_zero), 32'd1);
    check_val("rst_sign", 32'(ac_sign), 32'd0);
    rst = 1'b0;
    tick();

    run_cmd("ldr8001", AC_CMD_LOAD_DR,  16'h0000, 1'b0, 16'h8001, 16'h8001, 1'b0, 1'b0);
    run_cmd("sna",     AC_CMD_SNA,      16'h0000, 1'b0, 16'h0000, 16'h8001, 1'b0, 1'b1);
    run_cmd("spa_neg", AC_CMD_SPA,      16'h0000, 1'b0, 16'h0000, 16'h8001, 1'b0, 1'b0);
    run_cmd("ldalu",   AC_CMD_LOAD_ALU, 16'h1234, 1'b1, 16'h5555, 16'h1234, 1'b1, 1'b0);
    run_cmd("spa_pos", AC_CMD_SPA,      16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b1);
    run_cmd("sna_pos", AC_CMD_SNA,      16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0);
    run_cmd("cme1",    AC_CMD_CME,      16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0);
    run_cmd("sze_hit", AC_CMD_SZE,      16'h0000, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b1);
    run_cmd("ldrffff", AC_CMD_LOAD_DR,  16'h0000, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    run_cmd("cme2",    AC_CMD_CME,      16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    run_cmd("inc_wrap",AC_CMD_INC,      16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    run_cmd("sza",     AC_CMD_SZA,      16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    run_cmd("cma",     AC_CMD_CMA,      16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    run_cmd("sze_miss",AC_CMD_SZE,      16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    run_cmd("inc_mid", AC_CMD_LOAD_DR,  16'h0000, 1'b0, 16'h00FE, 16'h00FE, 1'b1, 1'b0);
    run_cmd("inc_ff",  AC_CMD_INC,      16'h0000, 1'b0, 16'h0000, 16'h00FF, 1'b1, 1'b0);

    // cmd_valid held high: CLA, CLE, NOP accepted only in IDLE.
    burst_ops[0] = AC_CMD_CLA;
    burst_ops[1] = AC_CMD_CLE;
    burst_ops[2] = AC_CMD_NOP;
    n_done = 0;
    idx    = 0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (cmd_ready && idx < 3) begin
        cmd_op = burst_ops[idx];
        idx++;
      end
      tick();
      if (done) n_done++;
    end
    cmd_valid = 1'b0;
    check_val("burst_dones", 32'(n_done), 32'd3);
    check_val("burst_accepts", 32'(idx), 32'd3);
    check_val("burst_ac", 32'(ac), 32'h0);
    check_val("burst_e", 32'(e), 32'd0);
    tick();
    check_val("burst_done_low", 32'(done), 32'd0);

    run_cmd("ldr1234", AC_CMD_LOAD_DR,  16'h0000, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0);
    run_cmd("rsvd14",  4'd14,           16'hABCD, 1'b1, 16'h9999, 16'h1234, 1'b0, 1'b0);
    run_cmd("rsvd15",  4'd15,           16'hABCD, 1'b1, 16'h9999, 16'h1234, 1'b0, 1'b0);

    // Reset during EXEC aborts the command.
    cmd_op    = AC_CMD_LOAD_DR;
    data_in   = 16'h00FF;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_ac", 32'(ac), 32'h0);
    check_val("abort_ready", 32'(cmd_ready), 32'd1);
    check_val("abort_zero", 32'(ac_zero), 32'd1);
    tick();
    check_val("abort_done2", 32'(done), 32'd0);
    check_val("abort_ac2", 32'(ac), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
